// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state and port identifiers,
// plus a small helper used by the round-robin grant policy.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_port_t;

  // Returns the port that is not p.
  function automatic arb_port_t other_port(input arb_port_t p);
    return (p == ARB_I) ? ARB_D : ARB_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_grant_sel.sv
// Grant policy for the memory arbiter. Decides which CPU port wins when the
// arbiter is idle and holds the policy state updated on each accepted grant.
// Default build: fixed D priority with a starvation guard for the I port.
// Define ARB_ROUND_ROBIN_EN for alternating grants on ties.
module arb_grant_sel
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_pend,
  input  logic      d_pend,
  input  logic      grant_take,
  output arb_port_t grant
);

`ifdef ARB_ROUND_ROBIN_EN

  arb_port_t rr_ptr;

  // Pick the single pending port, or the pointed-to port on a tie.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = ARB_D;
    if (i_pend && !d_pend)
      grant = ARB_I;
    else if (i_pend && d_pend)
      grant = rr_ptr;
  end

  // After every grant, point at the port that was not just served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= ARB_I;
    else if (grant_take)
      rr_ptr <= other_port(grant);
  end

`else

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // D wins ties unless I has already lost STARVE_LIMIT consecutive ties.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = ARB_D;
    if (i_pend && !d_pend)
      grant = ARB_I;
    else if (i_pend && d_pend && starved)
      grant = ARB_I;
  end

  // Count D grants that left I waiting; saturate at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant_take) begin
      if (grant == ARB_I || !i_pend)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: serves the CPU instruction (imem_*) and data (mem_*) ports
// one transaction at a time over a single downstream port (pmem_*).
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin grants on ties);
// undefined gives fixed D priority with an I-port starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic [1:0]        imem_byte_enable,
  input  logic              imem_read,
  input  logic              imem_write,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        mem_byte_enable,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [1:0]        pmem_byte_enable,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state;
  arb_port_t  grant;
  logic       i_pend;
  logic       d_pend;
  logic       grant_take;

  assign i_pend     = imem_read | imem_write;
  assign d_pend     = mem_read | mem_write;
  assign grant_take = (state == IDLE) && (i_pend || d_pend);

  arb_grant_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_sel (
    .clk        (clk),
    .reset      (reset),
    .i_pend     (i_pend),
    .d_pend     (d_pend),
    .grant_take (grant_take),
    .grant      (grant)
  );

  // Transaction FSM; the pmem_* registers double as the request registers so
  // the downstream port never sees CPU address changes after the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      imem_rdata       <= '0;
      imem_resp        <= 1'b0;
      mem_rdata        <= '0;
      mem_resp         <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (grant_take) begin
            // Read and write together is illegal and is treated as a write.
            if (grant == ARB_I) begin
              pmem_address     <= imem_address;
              pmem_wdata       <= imem_wdata;
              pmem_byte_enable <= imem_byte_enable;
              pmem_write       <= imem_write;
              pmem_read        <= ~imem_write;
              state            <= SERVE_I;
            end else begin
              pmem_address     <= mem_address;
              pmem_wdata       <= mem_wdata;
              pmem_byte_enable <= mem_byte_enable;
              pmem_write       <= mem_write;
              pmem_read        <= ~mem_write;
              state            <= SERVE_D;
            end
          end
        end

        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (state == SERVE_I) begin
              if (pmem_read)
                imem_rdata <= pmem_rdata;
              imem_resp <= 1'b1;
              state     <= DONE_I;
            end else begin
              if (pmem_read)
                mem_rdata <= pmem_rdata;
              mem_resp <= 1'b1;
              state    <= DONE_D;
            end
          end
        end

        DONE_I, DONE_D: begin
          imem_resp <= 1'b0;
          mem_resp  <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: single-port read/write, tie handling,
// starvation guard (or round-robin alternation), zero-wait pulses and
// asynchronous reset in the middle of a transaction.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_wdata;
  logic [1:0]        imem_byte_enable;
  logic              imem_read;
  logic              imem_write;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_resp;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_byte_enable;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;
  logic [ADDR_W-1:0] pmem_address;
  logic [DATA_W-1:0] pmem_wdata;
  logic [1:0]        pmem_byte_enable;
  logic              pmem_read;
  logic              pmem_write;
  logic [DATA_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_wdata       (imem_wdata),
    .imem_byte_enable (imem_byte_enable),
    .imem_read        (imem_read),
    .imem_write       (imem_write),
    .imem_rdata       (imem_rdata),
    .imem_resp        (imem_resp),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_byte_enable  (mem_byte_enable),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] second_addr;
  logic [ADDR_W-1:0] exp_addr;

  initial begin
    reset            = 1'b1;
    imem_address     = '0;
    imem_wdata       = '0;
    imem_byte_enable = 2'b11;
    imem_read        = 1'b0;
    imem_write       = 1'b0;
    mem_address      = '0;
    mem_wdata        = '0;
    mem_byte_enable  = 2'b11;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    pmem_rdata       = '0;
    pmem_resp        = 1'b0;

    // Reset state.
    step();
    step();
    check("rst_pmem_read",  pmem_read,    0);
    check("rst_pmem_write", pmem_write,   0);
    check("rst_imem_resp",  imem_resp,    0);
    check("rst_mem_resp",   mem_resp,     0);
    check("rst_imem_rdata", imem_rdata,   0);
    check("rst_mem_rdata",  mem_rdata,    0);
    check("rst_pmem_addr",  pmem_address, 0);
    reset = 1'b0;
    step();

    // I read at 0x3000, pmem_resp three strobe cycles later with 0xBEEF.
    imem_address = 16'h3000;
    imem_read    = 1'b1;
    step();                                   // cycle 1
    check("ird_strobe",     pmem_read,    1);
    check("ird_no_write",   pmem_write,   0);
    check("ird_addr",       pmem_address, 16'h3000);
    imem_address = 16'hFFFF;                  // must not reach downstream
    step();                                   // cycle 2
    check("ird_isolate",    pmem_address, 16'h3000);
    check("ird_no_resp",    imem_resp,    0);
    step();                                   // cycle 3
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hBEEF;
    step();                                   // cycle 4
    check("ird_resp",       imem_resp,    1);
    check("ird_rdata",      imem_rdata,   16'hBEEF);
    check("ird_mem_resp",   mem_resp,     0);
    check("ird_strobe_off", pmem_read,    0);
    pmem_resp = 1'b0;
    imem_read = 1'b0;
    step();
    check("ird_pulse_w",    imem_resp,    0);
    check("ird_hold",       imem_rdata,   16'hBEEF);

    // D write 0x1234 to 0x4002, low byte only; zero-wait pmem.
    mem_address     = 16'h4002;
    mem_wdata       = 16'h1234;
    mem_byte_enable = 2'b01;
    mem_write       = 1'b1;
    step();
    check("dwr_write",      pmem_write,       1);
    check("dwr_no_read",    pmem_read,        0);
    check("dwr_addr",       pmem_address,     16'h4002);
    check("dwr_wdata",      pmem_wdata,       16'h1234);
    check("dwr_be",         pmem_byte_enable, 2'b01);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hDEAD;
    step();
    check("dwr_resp",       mem_resp,         1);
    check("dwr_rdata_keep", mem_rdata,        0);
    check("dwr_imem_resp",  imem_resp,        0);
    pmem_resp = 1'b0;
    mem_write = 1'b0;
    step();
    check("dwr_pulse_w",    mem_resp,         0);
    check("dwr_strobe_off", pmem_write,       0);

    // Tie: both ports read in the same cycle.
`ifdef ARB_ROUND_ROBIN_EN
    first_addr  = 16'h1000;
    second_addr = 16'h2000;
`else
    first_addr  = 16'h2000;
    second_addr = 16'h1000;
`endif
    imem_address    = 16'h1000;
    mem_address     = 16'h2000;
    mem_byte_enable = 2'b11;
    imem_read       = 1'b1;
    mem_read        = 1'b1;
    step();
    check("tie_first",      pmem_address, first_addr);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'h5555;
    step();
    if (first_addr == 16'h2000) begin
      check("tie_d_resp",   mem_resp,   1);
      check("tie_d_rdata",  mem_rdata,  16'h5555);
      check("tie_i_wait",   imem_resp,  0);
      check("tie_i_keep",   imem_rdata, 16'hBEEF);
      mem_read = 1'b0;
    end else begin
      check("tie_i_resp",   imem_resp,  1);
      check("tie_i_rdata",  imem_rdata, 16'h5555);
      check("tie_d_wait",   mem_resp,   0);
      check("tie_d_keep",   mem_rdata,  0);
      imem_read = 1'b0;
    end
    pmem_resp = 1'b0;
    step();                                   // IDLE
    check("tie_idle_quiet", pmem_read, 0);
    step();
    check("tie_second",     pmem_address, second_addr);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'h6666;
    step();
    check("tie_second_resp", imem_resp | mem_resp, 1);
    pmem_resp = 1'b0;
    imem_read = 1'b0;
    mem_read  = 1'b0;
    step();

    // Both ports held pending; five grants in a row.
    imem_address = 16'h0AAA;
    mem_address  = 16'h0DDD;
    imem_read    = 1'b1;
    mem_read     = 1'b1;
    for (int g = 0; g < 5; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_addr = (g % 2 == 0) ? 16'h0AAA : 16'h0DDD;
`else
      exp_addr = (g < 4) ? 16'h0DDD : 16'h0AAA;
`endif
      step();
      check($sformatf("starve_grant%0d", g), pmem_address, exp_addr);
      pmem_resp  = 1'b1;
      pmem_rdata = 16'h0100 + 16'(g);
      step();
      if (exp_addr == 16'h0AAA)
        check($sformatf("starve_irdata%0d", g), imem_rdata, 16'h0100 + 16'(g));
      else
        check($sformatf("starve_drdata%0d", g), mem_rdata, 16'h0100 + 16'(g));
      pmem_resp = 1'b0;
      step();
    end
    imem_read = 1'b0;
    mem_read  = 1'b0;
    step();

    // Reset asserted while serving D: outputs clear without a clock edge.
    mem_address = 16'h7777;
    mem_read    = 1'b1;
    step();
    check("rstmid_serving", pmem_read, 1);
    reset = 1'b1;
    #1;
    check("rstmid_pread",   pmem_read,    0);
    check("rstmid_pwrite",  pmem_write,   0);
    check("rstmid_mresp",   mem_resp,     0);
    check("rstmid_mrdata",  mem_rdata,    0);
    check("rstmid_irdata",  imem_rdata,   0);
    check("rstmid_paddr",   pmem_address, 0);
    mem_read = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("rstmid_idle",    pmem_read, 0);

    // Read and write together on I: treated as a write, rdata untouched.
    imem_address = 16'h0123;
    imem_wdata   = 16'hA5A5;
    imem_read    = 1'b1;
    imem_write   = 1'b1;
    step();
    check("rw_is_write",    pmem_write, 1);
    check("rw_no_read",     pmem_read,  0);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hCAFE;
    step();
    check("rw_resp",        imem_resp,  1);
    check("rw_rdata_keep",  imem_rdata, 0);
    pmem_resp  = 1'b0;
    imem_read  = 1'b0;
    imem_write = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
